player_mover: RTL and testbench
===============================

Name: player_mover

Overview:
- Parametrised next-generation player motion unit for the raycaster game loop.
- Once per game tick it:
  - applies turn input and forward/backward movement along an externally supplied direction vector;
  - probes the map grid for collisions;
  - commits the new pose.
- Adds features the previous unit lacks:
  - simultaneous turn+move;
  - wall sliding (per-axis fallback when the diagonal target is blocked);
  - out-of-bounds blocking;
  - configurable grid-read latency.

Parameters:
- X_W, 14, x position width (unsigned fixed point)
- Y_W, 13, y position width
- ANG_W, 8, angle width (full circle = 2^ANG_W)
- CELL_SHIFT, 8, position-to-grid shift; grid_x = x>>CELL_SHIFT
- TURN_STEP, 10, angle increment per tick
- TICK_W, 20, tick divider counter width (>=1)
- GRID_LAT, 1, cycles from grid_x/grid_y change to valid grid_out (>=1)

Ports:
- clock  in  1  system clock
- reset  in  1  reset, synchronous, active-high
- start  in  1  request one update; sampled only in IDLE
- done  out  1  one-cycle pulse when the pose is committed
- turn_right, turn_left, move_forward, move_backward  in  1 each  keyboard levels
- dir_x  in  X_W+1  signed step vector x for cur_angle (from angle-to-vector table)
- dir_y  in  Y_W+1  signed step vector y
- cur_pos_x  in  X_W;  cur_pos_y  in  Y_W;  cur_angle  in  ANG_W  current pose
- next_pos_x  out  X_W;  next_pos_y  out  Y_W;  next_angle  out  ANG_W  registered committed pose
- grid_x  out  X_W-CELL_SHIFT;  grid_y  out  Y_W-CELL_SHIFT  probe cell address, registered
- grid_out  in  3  cell type; 0 = empty

Behaviour:
- Reset:
  - state returns to IDLE; counter cleared; done=0; grid_x=grid_y=0;
  - next_* load cur_*.
  - Reset mid-operation abandons the update with no partial commit.
- Tick counter: free-running, TICK_W bits, wraps.
- States:
  - IDLE: on start go to WAIT_TICK; otherwise stay.
  - WAIT_TICK: go to PLAN when counter==0.
  - PLAN: latch inputs (details below).
  - PROBE_XY: drive grid_x/grid_y = (tx>>CELL_SHIFT, ty>>CELL_SHIFT); wait GRID_LAT cycles, then sample grid_out.
    - Free and in range: accept both axes, go to COMMIT.
    - Otherwise go to PROBE_X.
  - PROBE_X: probe the cell (tx, cur_y). If free and x in range, accept x. Go to PROBE_Y.
  - PROBE_Y: probe the cell (cur_x, ty). If free and y in range, accept y. Go to COMMIT.
  - COMMIT: next_pos_x/y = accepted axes, else cur; next_angle = ta. Go to DONE.
  - DONE: done=1 for exactly this cycle; go to IDLE.
- PLAN details:
  - Latch cur_* and dir_*.
  - Angle target ta:
    - cur_angle+TURN_STEP if only turn_right;
    - cur_angle-TURN_STEP if only turn_left;
    - cur_angle otherwise;
    - arithmetic modulo 2^ANG_W.
  - Move sign:
    - +1 if only move_forward;
    - -1 if only move_backward;
    - 0 if neither or both.
  - Compute tx/ty = cur ± sign-extended dir at width X_W+2 / Y_W+2.
  - Out-of-range flag per axis: result <0 or >=2^W.
  - If sign=0: skip probes, go to COMMIT.
- Turning is never blocked by collision. Movement is evaluated against the current angle's vector, not ta.
- An axis with a zero dir component is treated as unchanged and always accepted.
- start asserted while not in IDLE is ignored; no queuing.
- Worst-case latency from PLAN to done: 3*(GRID_LAT+1)+3 cycles plus the tick wait.

Decomposition:
- Shared package player_pkg:
  - state encodings;
  - GRID_EMPTY=3'd0;
  - default widths and TURN_STEP.
- Sub-module grid_probe:
  - registers the cell address;
  - counts GRID_LAT;
  - returns probe_free/probe_done.
  - Instantiated once and reused for all three probes.

Test Plan:
Benches use TICK_W=4, GRID_LAT=2, and a map model that returns grid_out after 2 cycles.
- Open map, cur=(1000,1000,0), dir=(+20,-30), move_forward, start → done pulse; next=(1020,970,0).
- turn_left, angle=5, no move → next_angle=251 (wrap); pos unchanged; no probe states entered.
- Diagonal cell (4,3) walled, (4,4) free; cur=(1020,1030), dir=(+20,-20), forward → x-only slide; next=(1040,1030).
- All three probe cells walled, with turn_right+forward, angle=250 → pos unchanged; next_angle=4.
- cur_x=10, dir_x=+20, move_backward → x out of range, blocked; y moves if free; both forward+backward pressed → no movement.
- Assert reset during the PROBE_X wait → next_* equal cur_*, done stays 0, IDLE next cycle; start during PROBE_Y is ignored.

Source files
------------

// File: rtl/player_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | player_pkg : shared states, cell encoding and default widths             |
// | Revision   : 1.0                                                         |
// +--------------------------------------------------------------------------+
package player_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_TICK = 3'd1,
    S_PLAN      = 3'd2,
    S_PROBE_XY  = 3'd3,
    S_PROBE_X   = 3'd4,
    S_PROBE_Y   = 3'd5,
    S_COMMIT    = 3'd6,
    S_DONE      = 3'd7
  } state_t;

  localparam logic [2:0] GRID_EMPTY = 3'd0;

  localparam int DEF_X_W        = 14;
  localparam int DEF_Y_W        = 13;
  localparam int DEF_ANG_W      = 8;
  localparam int DEF_CELL_SHIFT = 8;
  localparam int DEF_TURN_STEP  = 10;
  localparam int DEF_TICK_W     = 20;
  localparam int DEF_GRID_LAT   = 1;

endpackage
`default_nettype wire

// File: rtl/player_mover_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | player_mover_if : pose, keyboard, direction and grid-probe signals       |
// | Revision        : 1.0                                                    |
// +--------------------------------------------------------------------------+
interface player_mover_if
  import player_pkg::*;
#(
  parameter int X_W        = DEF_X_W,
  parameter int Y_W        = DEF_Y_W,
  parameter int ANG_W      = DEF_ANG_W,
  parameter int CELL_SHIFT = DEF_CELL_SHIFT
);

  logic                        start;
  logic                        done;
  logic                        turn_right;
  logic                        turn_left;
  logic                        move_forward;
  logic                        move_backward;
  logic signed [X_W:0]         dir_x;
  logic signed [Y_W:0]         dir_y;
  logic [X_W-1:0]              cur_pos_x;
  logic [Y_W-1:0]              cur_pos_y;
  logic [ANG_W-1:0]            cur_angle;
  logic [X_W-1:0]              next_pos_x;
  logic [Y_W-1:0]              next_pos_y;
  logic [ANG_W-1:0]            next_angle;
  logic [X_W-CELL_SHIFT-1:0]   grid_x;
  logic [Y_W-CELL_SHIFT-1:0]   grid_y;
  logic [2:0]                  grid_out;

  modport master (
    output start, turn_right, turn_left, move_forward, move_backward,
    output dir_x, dir_y, cur_pos_x, cur_pos_y, cur_angle, grid_out,
    input  done, next_pos_x, next_pos_y, next_angle, grid_x, grid_y
  );

  modport slave (
    input  start, turn_right, turn_left, move_forward, move_backward,
    input  dir_x, dir_y, cur_pos_x, cur_pos_y, cur_angle, grid_out,
    output done, next_pos_x, next_pos_y, next_angle, grid_x, grid_y
  );

endinterface
`default_nettype wire

// File: rtl/grid_probe.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | grid_probe : registers a cell address and flags when grid_out is valid   |
// | Revision   : 1.0                                                         |
// +--------------------------------------------------------------------------+
module grid_probe
  import player_pkg::*;
#(
  parameter int GX_W     = 6,
  parameter int GY_W     = 5,
  parameter int GRID_LAT = DEF_GRID_LAT
) (
  input  wire logic            clock,
  input  wire logic            reset,
  input  wire logic            i_req,
  input  wire logic [GX_W-1:0] i_addr_x,
  input  wire logic [GY_W-1:0] i_addr_y,
  input  wire logic [2:0]      i_grid_out,
  output logic      [GX_W-1:0] o_grid_x,
  output logic      [GY_W-1:0] o_grid_y,
  output logic                 o_probe_done,
  output logic                 o_probe_free
);

  localparam int CNT_W = $clog2(GRID_LAT + 1);

  logic [GX_W-1:0]  r_grid_x;
  logic [GY_W-1:0]  r_grid_y;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;

  // The address lands on the request edge; the last count cycle is the one
  // whose closing edge sees a valid grid_out.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_grid_x <= '0;
      r_grid_y <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
    end else if (i_req) begin
      r_grid_x <= i_addr_x;
      r_grid_y <= i_addr_y;
      r_cnt    <= CNT_W'(GRID_LAT);
      r_busy   <= 1'b1;
    end else if (r_busy) begin
      r_cnt <= r_cnt - 1'b1;
      if (r_cnt == CNT_W'(1)) begin
        r_busy <= 1'b0;
      end
    end
  end

  assign o_grid_x     = r_grid_x;
  assign o_grid_y     = r_grid_y;
  assign o_probe_done = r_busy && (r_cnt == CNT_W'(1));
  assign o_probe_free = (i_grid_out == GRID_EMPTY);

endmodule
`default_nettype wire

// File: rtl/player_mover.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | player_mover : per-tick turn, move, collision probe and pose commit      |
// | Revision     : 1.0                                                       |
// +--------------------------------------------------------------------------+
module player_mover
  import player_pkg::*;
#(
  parameter int X_W        = DEF_X_W,
  parameter int Y_W        = DEF_Y_W,
  parameter int ANG_W      = DEF_ANG_W,
  parameter int CELL_SHIFT = DEF_CELL_SHIFT,
  parameter int TURN_STEP  = DEF_TURN_STEP,
  parameter int TICK_W     = DEF_TICK_W,
  parameter int GRID_LAT   = DEF_GRID_LAT
) (
  input  wire logic     clock,
  input  wire logic     reset,
  player_mover_if.slave bus
);

  localparam int               GX_W   = X_W - CELL_SHIFT;
  localparam int               GY_W   = Y_W - CELL_SHIFT;
  localparam logic [ANG_W-1:0] C_TURN = ANG_W'(TURN_STEP);

  state_t           r_state;
  logic [TICK_W-1:0] r_tick;
  logic [X_W-1:0]   r_cur_x;
  logic [Y_W-1:0]   r_cur_y;
  logic [X_W-1:0]   r_tx;
  logic [Y_W-1:0]   r_ty;
  logic [ANG_W-1:0] r_ta;
  logic             r_oor_x;
  logic             r_oor_y;
  logic             r_zero_x;
  logic             r_zero_y;
  logic             r_acc_x;
  logic             r_acc_y;
  logic             r_req;
  logic             r_done;
  logic [X_W-1:0]   r_next_x;
  logic [Y_W-1:0]   r_next_y;
  logic [ANG_W-1:0] r_next_ang;

  logic             w_fwd;
  logic             w_bwd;
  logic             w_tr;
  logic             w_tl;
  logic [X_W+1:0]   w_base_x;
  logic [Y_W+1:0]   w_base_y;
  logic [X_W+1:0]   w_dx;
  logic [Y_W+1:0]   w_dy;
  logic [X_W+1:0]   w_tx;
  logic [Y_W+1:0]   w_ty;
  logic [ANG_W-1:0] w_ta;
  logic [GX_W-1:0]  w_addr_x;
  logic [GY_W-1:0]  w_addr_y;
  logic             w_probe_done;
  logic             w_probe_free;

  assign w_fwd = bus.move_forward & ~bus.move_backward;
  assign w_bwd = bus.move_backward & ~bus.move_forward;
  assign w_tr  = bus.turn_right & ~bus.turn_left;
  assign w_tl  = bus.turn_left & ~bus.turn_right;

  // Two guard bits: the top one catches underflow, the next one overflow.
  assign w_base_x = {2'b00, bus.cur_pos_x};
  assign w_base_y = {2'b00, bus.cur_pos_y};
  assign w_dx     = {bus.dir_x[X_W], bus.dir_x};
  assign w_dy     = {bus.dir_y[Y_W], bus.dir_y};

  assign w_tx = w_fwd ? (w_base_x + w_dx) : (w_bwd ? (w_base_x - w_dx) : w_base_x);
  assign w_ty = w_fwd ? (w_base_y + w_dy) : (w_bwd ? (w_base_y - w_dy) : w_base_y);
  assign w_ta = w_tr ? (bus.cur_angle + C_TURN)
              : (w_tl ? (bus.cur_angle - C_TURN) : bus.cur_angle);

  assign w_addr_x = (r_state == S_PROBE_Y) ? r_cur_x[X_W-1:CELL_SHIFT] : r_tx[X_W-1:CELL_SHIFT];
  assign w_addr_y = (r_state == S_PROBE_X) ? r_cur_y[Y_W-1:CELL_SHIFT] : r_ty[Y_W-1:CELL_SHIFT];

  grid_probe #(
    .GX_W     (GX_W),
    .GY_W     (GY_W),
    .GRID_LAT (GRID_LAT)
  ) u_probe (
    .clock        (clock),
    .reset        (reset),
    .i_req        (r_req),
    .i_addr_x     (w_addr_x),
    .i_addr_y     (w_addr_y),
    .i_grid_out   (bus.grid_out),
    .o_grid_x     (bus.grid_x),
    .o_grid_y     (bus.grid_y),
    .o_probe_done (w_probe_done),
    .o_probe_free (w_probe_free)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_tick     <= '0;
      r_cur_x    <= '0;
      r_cur_y    <= '0;
      r_tx       <= '0;
      r_ty       <= '0;
      r_ta       <= '0;
      r_oor_x    <= 1'b0;
      r_oor_y    <= 1'b0;
      r_zero_x   <= 1'b0;
      r_zero_y   <= 1'b0;
      r_acc_x    <= 1'b0;
      r_acc_y    <= 1'b0;
      r_req      <= 1'b0;
      r_done     <= 1'b0;
      r_next_x   <= bus.cur_pos_x;
      r_next_y   <= bus.cur_pos_y;
      r_next_ang <= bus.cur_angle;
    end else begin
      r_tick <= r_tick + 1'b1;
      r_done <= 1'b0;
      r_req  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_state <= S_WAIT_TICK;
          end
        end
        S_WAIT_TICK: begin
          if (r_tick == '0) begin
            r_state <= S_PLAN;
          end
        end
        S_PLAN: begin
          r_cur_x  <= bus.cur_pos_x;
          r_cur_y  <= bus.cur_pos_y;
          r_tx     <= w_tx[X_W-1:0];
          r_ty     <= w_ty[Y_W-1:0];
          r_ta     <= w_ta;
          r_oor_x  <= w_tx[X_W+1] | w_tx[X_W];
          r_oor_y  <= w_ty[Y_W+1] | w_ty[Y_W];
          r_zero_x <= (bus.dir_x == '0);
          r_zero_y <= (bus.dir_y == '0);
          r_acc_x  <= 1'b0;
          r_acc_y  <= 1'b0;
          if (w_fwd || w_bwd) begin
            r_req   <= 1'b1;
            r_state <= S_PROBE_XY;
          end else begin
            r_state <= S_COMMIT;
          end
        end
        S_PROBE_XY: begin
          if (w_probe_done) begin
            if (w_probe_free && !r_oor_x && !r_oor_y) begin
              r_acc_x <= 1'b1;
              r_acc_y <= 1'b1;
              r_state <= S_COMMIT;
            end else begin
              r_req   <= 1'b1;
              r_state <= S_PROBE_X;
            end
          end
        end
        S_PROBE_X: begin
          if (w_probe_done) begin
            r_acc_x <= r_zero_x | (w_probe_free & ~r_oor_x);
            r_req   <= 1'b1;
            r_state <= S_PROBE_Y;
          end
        end
        S_PROBE_Y: begin
          if (w_probe_done) begin
            r_acc_y <= r_zero_y | (w_probe_free & ~r_oor_y);
            r_state <= S_COMMIT;
          end
        end
        S_COMMIT: begin
          r_next_x   <= r_acc_x ? r_tx : r_cur_x;
          r_next_y   <= r_acc_y ? r_ty : r_cur_y;
          r_next_ang <= r_ta;
          r_done     <= 1'b1;
          r_state    <= S_DONE;
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.done       = r_done;
  assign bus.next_pos_x = r_next_x;
  assign bus.next_pos_y = r_next_y;
  assign bus.next_angle = r_next_ang;

endmodule
`default_nettype wire

// File: tb/tb_player_mover.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_player_mover : directed checks of player_mover with a walled map      |
// | Revision        : 1.0                                                    |
// +--------------------------------------------------------------------------+
module tb_player_mover;

  localparam int X_W        = 14;
  localparam int Y_W        = 13;
  localparam int ANG_W      = 8;
  localparam int CELL_SHIFT = 8;
  localparam int TURN_STEP  = 10;
  localparam int TICK_W     = 4;
  localparam int GRID_LAT   = 2;

  logic clock = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  logic [TICK_W-1:0] tb_tick;
  logic [2:0]        map_q [0:63][0:31];

  player_mover_if #(
    .X_W(X_W), .Y_W(Y_W), .ANG_W(ANG_W), .CELL_SHIFT(CELL_SHIFT)
  ) bus ();

  player_mover #(
    .X_W(X_W), .Y_W(Y_W), .ANG_W(ANG_W), .CELL_SHIFT(CELL_SHIFT),
    .TURN_STEP(TURN_STEP), .TICK_W(TICK_W), .GRID_LAT(GRID_LAT)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  // Map: cell type is valid two cycles after the address changes.
  always @(posedge clock) bus.grid_out <= map_q[bus.grid_x][bus.grid_y];

  always @(posedge clock) begin
    if (reset) tb_tick <= '0;
    else       tb_tick <= tb_tick + 1'b1;
  end

  task automatic clear_map();
    for (int i = 0; i < 64; i++)
      for (int j = 0; j < 32; j++)
        map_q[i][j] = 3'd0;
  endtask

  task automatic set_pose(input logic [13:0] cx, input logic [12:0] cy, input logic [7:0] ca,
                          input logic signed [14:0] dx, input logic signed [13:0] dy,
                          input logic tr, input logic tl, input logic mf, input logic mb);
    bus.cur_pos_x = cx;  bus.cur_pos_y = cy;  bus.cur_angle = ca;
    bus.dir_x = dx;      bus.dir_y = dy;
    bus.turn_right = tr; bus.turn_left = tl;
    bus.move_forward = mf; bus.move_backward = mb;
  endtask

  // Returns cycles from PLAN through the done cycle inclusive, or -1 on timeout.
  task automatic run_update(input int poke_at, output int lat);
    int k;
    @(negedge clock);
    bus.start = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
    k = 0;
    while (tb_tick != '0 && k < 40) begin
      @(negedge clock);
      k++;
    end
    @(negedge clock);
    lat = 1;
    while (bus.done !== 1'b1 && lat < 40) begin
      bus.start = (lat == poke_at);
      @(negedge clock);
      lat++;
    end
    bus.start = 1'b0;
    if (lat >= 40) lat = -1;
  endtask

  task automatic test_reset();
    set_pose(14'd111, 13'd222, 8'd33, 15'sd0, 14'sd0, 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    total++;
    if (bus.done !== 1'b0) begin
      bad++; $display("FAIL reset_done: got %b expected 0", bus.done);
    end
    total++;
    if ({bus.grid_x, bus.grid_y} !== 11'd0) begin
      bad++; $display("FAIL reset_grid: got %0d,%0d expected 0,0", bus.grid_x, bus.grid_y);
    end
    total++;
    if ({bus.next_pos_x, bus.next_pos_y, bus.next_angle} !== {14'd111, 13'd222, 8'd33}) begin
      bad++; $display("FAIL reset_pose: got %0d,%0d,%0d expected 111,222,33",
                      bus.next_pos_x, bus.next_pos_y, bus.next_angle);
    end
  endtask

  task automatic test_open_move();
    int lat;
    clear_map();
    set_pose(14'd1000, 13'd1000, 8'd0, 15'sd20, -14'sd30, 1'b0, 1'b0, 1'b1, 1'b0);
    run_update(0, lat);
    total++;
    if (lat != 6) begin
      bad++; $display("FAIL open_latency: got %0d expected 6", lat);
    end
    total++;
    if ({bus.next_pos_x, bus.next_pos_y, bus.next_angle} !== {14'd1020, 13'd970, 8'd0}) begin
      bad++; $display("FAIL open_pose: got %0d,%0d,%0d expected 1020,970,0",
                      bus.next_pos_x, bus.next_pos_y, bus.next_angle);
    end
    total++;
    if ({bus.grid_x, bus.grid_y} !== {6'd3, 5'd3}) begin
      bad++; $display("FAIL open_grid: got %0d,%0d expected 3,3", bus.grid_x, bus.grid_y);
    end
    @(negedge clock);
    total++;
    if (bus.done !== 1'b0) begin
      bad++; $display("FAIL open_pulse: got %b expected 0 one cycle after done", bus.done);
    end
  endtask

  task automatic test_turn_wrap();
    int lat;
    set_pose(14'd1020, 13'd970, 8'd5, 15'sd20, -14'sd30, 1'b0, 1'b1, 1'b0, 1'b0);
    run_update(0, lat);
    total++;
    if (lat != 3) begin
      bad++; $display("FAIL turn_latency: got %0d expected 3", lat);
    end
    total++;
    if ({bus.next_pos_x, bus.next_pos_y, bus.next_angle} !== {14'd1020, 13'd970, 8'd251}) begin
      bad++; $display("FAIL turn_pose: got %0d,%0d,%0d expected 1020,970,251",
                      bus.next_pos_x, bus.next_pos_y, bus.next_angle);
    end
  endtask

  task automatic test_slide();
    int lat;
    clear_map();
    map_q[4][3] = 3'd1;
    map_q[3][3] = 3'd2;
    set_pose(14'd1020, 13'd1030, 8'd0, 15'sd20, -14'sd20, 1'b0, 1'b0, 1'b1, 1'b0);
    run_update(0, lat);
    total++;
    if (lat != 12) begin
      bad++; $display("FAIL slide_latency: got %0d expected 12", lat);
    end
    total++;
    if ({bus.next_pos_x, bus.next_pos_y, bus.next_angle} !== {14'd1040, 13'd1030, 8'd0}) begin
      bad++; $display("FAIL slide_pose: got %0d,%0d,%0d expected 1040,1030,0",
                      bus.next_pos_x, bus.next_pos_y, bus.next_angle);
    end
    total++;
    if ({bus.grid_x, bus.grid_y} !== {6'd3, 5'd3}) begin
      bad++; $display("FAIL slide_grid: got %0d,%0d expected 3,3", bus.grid_x, bus.grid_y);
    end
  endtask

  task automatic test_all_blocked();
    int lat;
    map_q[4][4] = 3'd1;
    set_pose(14'd1020, 13'd1030, 8'd250, 15'sd20, -14'sd20, 1'b1, 1'b0, 1'b1, 1'b0);
    run_update(0, lat);
    total++;
    if (lat != 12) begin
      bad++; $display("FAIL blocked_latency: got %0d expected 12", lat);
    end
    total++;
    if ({bus.next_pos_x, bus.next_pos_y, bus.next_angle} !== {14'd1020, 13'd1030, 8'd4}) begin
      bad++; $display("FAIL blocked_pose: got %0d,%0d,%0d expected 1020,1030,4",
                      bus.next_pos_x, bus.next_pos_y, bus.next_angle);
    end
  endtask

  task automatic test_bounds();
    int lat;
    clear_map();
    // Backward from x=10 underflows x; y still moves.
    set_pose(14'd10, 13'd1000, 8'd0, 15'sd20, -14'sd30, 1'b0, 1'b0, 1'b0, 1'b1);
    run_update(0, lat);
    total++;
    if (lat != 12) begin
      bad++; $display("FAIL under_latency: got %0d expected 12", lat);
    end
    total++;
    if ({bus.next_pos_x, bus.next_pos_y, bus.next_angle} !== {14'd10, 13'd1030, 8'd0}) begin
      bad++; $display("FAIL under_pose: got %0d,%0d,%0d expected 10,1030,0",
                      bus.next_pos_x, bus.next_pos_y, bus.next_angle);
    end
    set_pose(14'd10, 13'd1000, 8'd0, 15'sd20, -14'sd30, 1'b0, 1'b0, 1'b1, 1'b1);
    run_update(0, lat);
    total++;
    if (lat != 3) begin
      bad++; $display("FAIL both_keys_latency: got %0d expected 3", lat);
    end
    total++;
    if ({bus.next_pos_x, bus.next_pos_y, bus.next_angle} !== {14'd10, 13'd1000, 8'd0}) begin
      bad++; $display("FAIL both_keys_pose: got %0d,%0d,%0d expected 10,1000,0",
                      bus.next_pos_x, bus.next_pos_y, bus.next_angle);
    end
    set_pose(14'd500, 13'd8190, 8'd0, 15'sd0, 14'sd5, 1'b0, 1'b0, 1'b1, 1'b0);
    run_update(0, lat);
    total++;
    if (lat != 12) begin
      bad++; $display("FAIL over_latency: got %0d expected 12", lat);
    end
    total++;
    if ({bus.next_pos_x, bus.next_pos_y, bus.next_angle} !== {14'd500, 13'd8190, 8'd0}) begin
      bad++; $display("FAIL over_pose: got %0d,%0d,%0d expected 500,8190,0",
                      bus.next_pos_x, bus.next_pos_y, bus.next_angle);
    end
    set_pose(14'd500, 13'd8186, 8'd0, 15'sd0, 14'sd5, 1'b0, 1'b0, 1'b1, 1'b0);
    run_update(0, lat);
    total++;
    if (lat != 6) begin
      bad++; $display("FAIL edge_latency: got %0d expected 6", lat);
    end
    total++;
    if ({bus.next_pos_x, bus.next_pos_y, bus.next_angle} !== {14'd500, 13'd8191, 8'd0}) begin
      bad++; $display("FAIL edge_pose: got %0d,%0d,%0d expected 500,8191,0",
                      bus.next_pos_x, bus.next_pos_y, bus.next_angle);
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    int k;
    int seen;
    clear_map();
    map_q[4][3] = 3'd1;
    map_q[3][3] = 3'd1;
    set_pose(14'd1020, 13'd1030, 8'd0, 15'sd20, -14'sd20, 1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge clock);
    bus.start = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
    k = 0;
    while (tb_tick != '0 && k < 40) begin
      @(negedge clock);
      k++;
    end
    @(negedge clock);
    for (int c = 1; c < 6; c++) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    total++;
    if (bus.done !== 1'b0) begin
      bad++; $display("FAIL midreset_done: got %b expected 0", bus.done);
    end
    total++;
    if ({bus.next_pos_x, bus.next_pos_y, bus.next_angle} !== {14'd1020, 13'd1030, 8'd0}) begin
      bad++; $display("FAIL midreset_pose: got %0d,%0d,%0d expected 1020,1030,0",
                      bus.next_pos_x, bus.next_pos_y, bus.next_angle);
    end
    total++;
    if ({bus.grid_x, bus.grid_y} !== 11'd0) begin
      bad++; $display("FAIL midreset_grid: got %0d,%0d expected 0,0", bus.grid_x, bus.grid_y);
    end
    reset = 1'b0;
    seen = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clock);
      if (bus.done === 1'b1) seen++;
    end
    total++;
    if (seen != 0) begin
      bad++; $display("FAIL midreset_quiet: got %0d done pulses expected 0", seen);
    end
    run_update(0, lat);
    total++;
    if (lat != 12) begin
      bad++; $display("FAIL after_reset_latency: got %0d expected 12", lat);
    end
    total++;
    if ({bus.next_pos_x, bus.next_pos_y, bus.next_angle} !== {14'd1040, 13'd1030, 8'd0}) begin
      bad++; $display("FAIL after_reset_pose: got %0d,%0d,%0d expected 1040,1030,0",
                      bus.next_pos_x, bus.next_pos_y, bus.next_angle);
    end
  endtask

  task automatic test_start_ignored();
    int lat;
    int seen;
    map_q[4][4] = 3'd3;
    set_pose(14'd1020, 13'd1030, 8'd0, 15'sd20, -14'sd20, 1'b1, 1'b0, 1'b1, 1'b0);
    run_update(9, lat);
    total++;
    if (lat != 12) begin
      bad++; $display("FAIL ignore_latency: got %0d expected 12", lat);
    end
    total++;
    if ({bus.next_pos_x, bus.next_pos_y, bus.next_angle} !== {14'd1020, 13'd1030, 8'd10}) begin
      bad++; $display("FAIL ignore_pose: got %0d,%0d,%0d expected 1020,1030,10",
                      bus.next_pos_x, bus.next_pos_y, bus.next_angle);
    end
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clock);
      if (bus.done === 1'b1) seen++;
    end
    total++;
    if (seen != 0) begin
      bad++; $display("FAIL ignore_quiet: got %0d extra done pulses expected 0", seen);
    end
  endtask

  initial begin
    reset     = 1'b1;
    bus.start = 1'b0;
    clear_map();
    test_reset();
    test_open_move();
    test_turn_wrap();
    test_slide();
    test_all_blocked();
    test_bounds();
    test_reset_mid();
    test_start_ignored();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
